// File: rtl/membus_arbiter.sv
// membus_arbiter: single-port RAM arbiter between instruction fetch and the
// data (mem stage) port. Requests are serialised onto one RAM bus with a
// fixed latency. Each requester sees a stall request until its access
// reaches the response cycle.
//
// Parameters:
//   RAM_LATENCY  cycles from ram_ce high to valid ram_rdata (legal 1..15)
//
// Optional feature, selected by the ARB_IBUF_EN macro:
//   defined   -> one-entry instruction buffer; a repeat fetch of the buffered
//                address is answered combinationally without a RAM access
//   undefined -> every fetch goes through the RAM
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_en/if_addr                 fetch request and word-aligned address
//   if_data, stallreq_from_if     fetched instruction, fetch stall request
//   mem_en/we/sel/addr/wdata      data request fields
//   mem_rdata, stallreq_from_mem  read data, data stall request
//   ram_ce/we/sel/addr/wdata      RAM command bus
//   ram_rdata                     RAM read data
module membus_arbiter #(
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        stallreq_from_if,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        stallreq_from_mem,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            we_q, we_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ram_ce_q, ram_ce_d;
  logic            ram_we_q, ram_we_d;
  logic [DW-1:0]   if_data_q, if_data_d;
  logic [DW-1:0]   mem_rdata_q, mem_rdata_d;
  logic            capture;

  logic            ibuf_hit;
  logic [DW-1:0]   ibuf_rdata;

`ifdef ARB_IBUF_EN
  logic            ibuf_valid_q;
  logic [AW-1:0]   ibuf_tag_q;
  logic [DW-1:0]   ibuf_data_q;
  logic            ibuf_clr;

  assign ibuf_hit   = !rst && if_en && ibuf_valid_q && (if_addr == ibuf_tag_q);
  assign ibuf_rdata = ibuf_data_q;
  // A granted data write may alias the buffered instruction, so drop it.
  assign ibuf_clr   = (state_q == IDLE) && mem_en && mem_we;

  // Instruction buffer: filled by each completed fetch, cleared by writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ibuf_valid_q <= 1'b0;
      ibuf_tag_q   <= '0;
      ibuf_data_q  <= '0;
    end else if (ibuf_clr) begin
      ibuf_valid_q <= 1'b0;
    end else if (capture && (owner_q == OWN_IF)) begin
      ibuf_valid_q <= 1'b1;
      ibuf_tag_q   <= addr_q;
      ibuf_data_q  <= ram_rdata;
    end
  end
`else
  assign ibuf_hit   = 1'b0;
  assign ibuf_rdata = '0;
`endif

  // Next-state, latched request fields and response capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    capture     = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins ties: the mem stage holds the older instruction.
        if (mem_en) begin
          owner_d = OWN_MEM;
          we_d    = mem_we;
          sel_d   = mem_sel;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          cnt_d   = CW'(RAM_LATENCY);
          state_d = BUSY;
        end else if (if_en && !ibuf_hit) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          sel_d   = {SW{1'b1}};
          addr_d  = if_addr;
          wdata_d = '0;
          cnt_d   = CW'(RAM_LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output registers double as the response register; a write returns 0.
    if (capture) begin
      if (owner_q == OWN_IF) begin
        if_data_d = ram_rdata;
      end else begin
        mem_rdata_d = we_q ? '0 : ram_rdata;
      end
    end
  end

  // RAM strobes are registered so they are high exactly for the BUSY cycles.
  assign ram_ce_d = (state_d == BUSY);
  assign ram_we_d = (state_d == BUSY) && we_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_sel   = sel_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign if_data   = ibuf_hit ? ibuf_rdata : if_data_q;
  assign mem_rdata = mem_rdata_q;

  // Stall until the requester's own response cycle; quiet during reset.
  assign stallreq_from_if  = !rst && if_en && !ibuf_hit &&
                             !((state_q == RESP) && (owner_q == OWN_IF));
  assign stallreq_from_mem = !rst && mem_en &&
                             !((state_q == RESP) && (owner_q == OWN_MEM));

endmodule

// File: doc/membus_arbiter.md
# membus_arbiter

Single-port memory arbiter between the instruction-fetch port (pc) and the data port (mem stage). It serialises both onto one RAM bus with a fixed access latency and raises per-requester stall requests into ctrl so the pipeline freezes until each access completes. It sits between pc/mem and data_ram, replacing their direct connection.

## Interface

- RAM_LATENCY, 1: cycles the RAM needs from ram_ce high to valid ram_rdata; legal range 1..15.

- clk  in  1  pipeline clock; all state changes on rising edge
- rst  in  1  reset_status_t; synchronous, active-high (RstEnable = 1)
- if_en  in  1  fetch request
- if_addr  in  32  fetch byte address (word aligned)
- if_data  out  32  fetched instruction
- stallreq_from_if  out  1  fetch not complete this cycle
- mem_en  in  1  data request
- mem_we  in  1  1 = write, 0 = read
- mem_sel  in  4  byte enables
- mem_addr  in  32  data byte address
- mem_wdata  in  32  write data
- mem_rdata  out  32  read data
- stallreq_from_mem  out  1  data access not complete this cycle
- ram_ce, ram_we  out  1 each  RAM chip enable / write enable
- ram_sel  out  4  RAM byte enables
- ram_addr, ram_wdata  out  32 each  RAM address / write data
- ram_rdata  in  32  RAM read data

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE: if mem_en, grant data; else if if_en, grant fetch; else stay. On grant, latch owner, we, sel, addr, wdata; load counter = RAM_LATENCY; go BUSY.
- BUSY: drive ram_ce=1 and latched ram_* fields. Decrement counter each cycle. On counter==1, capture ram_rdata into the response register and go RESP.
- RESP: ram_ce=0. The owner's data output shows the response register and its stallreq is 0 for exactly this cycle. Next state is IDLE.
- stallreq_x = x_en and not (state==RESP and owner==x). A non-owner requesting during BUSY/RESP stays stalled.
- Priority: data always beats fetch on simultaneous requests. The mem stage is older, and its stall freezes fetch anyway.
- Writes: RAM performs the write with latched sel; mem_rdata in RESP is 0.
- Requester must hold en/addr/wdata stable while stalled.
- Requester drops en mid-BUSY (flush): the access still runs to completion, so no torn write. RESP occurs but no output update is consumed; the response register is overwritten.
- Outputs outside RESP: if_data/mem_rdata hold their last delivered values.

## Timing

- Access latency: request cycle (IDLE, stalled) + RAM_LATENCY BUSY cycles + 1 RESP cycle = RAM_LATENCY+2 cycles. The pipeline advances on the edge ending RESP.
- Back-to-back: a new grant is evaluated in the IDLE cycle after RESP. There is no bubble-free chaining.
- Fetch waiting behind data: fetch is granted in the IDLE following data RESP, if if_en is still high.
- Reset (rst=1 at an edge, including mid-BUSY): next cycle state=IDLE; ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, if_data, mem_rdata all 0; counter 0. While rst=1, both stallreq outputs are 0. An aborted write may or may not have reached RAM.

## Configuration

- ARB_IBUF_EN defined: a one-entry instruction buffer (valid, tag addr, data).
  - A fetch with valid and if_addr==tag, seen in any state, returns buffer data combinationally with stallreq_from_if=0 and no RAM access.
  - A fetch RESP fills the buffer.
  - Any data write (granted, mem_we=1) clears valid.
  - Reset clears valid.
- ARB_IBUF_EN undefined: no buffer; every fetch goes through the FSM.

## Test plan

- Reset then fetch only, RAM_LATENCY=1, if_addr=0x0000_0010, RAM word 0x3401_1100 -> stallreq_from_if=1 for 2 cycles; cycle 3 if_data=0x3401_1100, stall 0; ram_ce high exactly 1 cycle.
- Simultaneous if_en and mem_en read of 0x0000_0100 (=0xDEAD_BEEF), RAM_LATENCY=3 -> data served first (RESP at cycle 5, mem_rdata=0xDEAD_BEEF); fetch RESP at cycle 10; stallreq_from_if high cycles 1-9.
- Write sel=4'b0011, wdata=0x1234_5678 to 0x200 over 0xAAAA_AAAA, then read -> 0xAAAA_5678; ram_we high only during write BUSY.
- rst asserted on 2nd BUSY cycle, RAM_LATENCY=4 -> next cycle ram_ce=0, all outputs 0, state IDLE; a following fetch completes normally.
- mem_en dropped mid-BUSY -> ram_ce still held for all RAM_LATENCY cycles; no stall on the next request beyond its own latency.
- With ARB_IBUF_EN: repeat fetch of 0x0000_0010 -> stall 0, ram_ce stays 0. A data write to any address, then the same fetch -> full RAM_LATENCY+2 access.
